disp_scan_ctrl: RTL

- Scan controller for the 4-digit multiplexed 7-segment display.
- Takes four 5-bit digit codes (seg0wr..seg3wr) from the digit-write logic and decodes them.
- Drives one digit at a time, rotating at a fixed refresh rate.
- New codes are double-buffered and committed only at frame boundaries via a request/acknowledge handshake, so a digit never changes mid-frame.

---
 rtl/disp_scan_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scan controller for a 4-digit multiplexed 7-segment display.
// Each digit is driven for TICK_DIV clocks, rotating 0->1->2->3. New digit codes
// go into shadow registers only at a frame boundary (idx wrapping 3->0), so a
// frame always shows one consistent set of digits.
// Optional blinking is compiled in with the macro DISP_SCAN_BLINK_EN.
module disp_scan_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int CNT_W        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] seg0wr,
  input  logic [4:0] seg1wr,
  input  logic [4:0] seg2wr,
  input  logic [4:0] seg3wr,
  input  logic [3:0] dp_in,
  input  logic       upd,
  input  logic       blink,
  output logic       upd_ack,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [4:0]       CODE_BLANK = 5'd16;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [3:0][4:0]  code_q, code_d;
  logic [3:0]       sdp_q, sdp_d;
  logic             upd_ack_q, upd_ack_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fs_q, fs_d;

  logic tick_wrap;
  logic frame_bnd;
  logic load;
  logic blank_an;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a 5-bit digit code.
  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:    decode = 7'h40;
      5'd1:    decode = 7'h79;
      5'd2:    decode = 7'h24;
      5'd3:    decode = 7'h30;
      5'd4:    decode = 7'h19;
      5'd5:    decode = 7'h12;
      5'd6:    decode = 7'h02;
      5'd7:    decode = 7'h78;
      5'd8:    decode = 7'h00;
      5'd9:    decode = 7'h10;
      5'd10:   decode = 7'h08;
      5'd11:   decode = 7'h03;
      5'd12:   decode = 7'h46;
      5'd13:   decode = 7'h21;
      5'd14:   decode = 7'h06;
      5'd15:   decode = 7'h0E;
      5'd17:   decode = 7'h3F;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Refresh tick, digit rotation and the upd -> shadow-load handshake.
  always_comb begin
    // NOTE: every signal in a combinational block gets a value on every path
    // (here directly, elsewhere via a default first) so no latch is inferred.
    tick_wrap = (cnt_q == TICK_LAST);
    frame_bnd = tick_wrap && (idx_q == 2'd3);
    // An upd arriving in the boundary cycle itself is honoured immediately.
    load      = frame_bnd && (pend_q || upd);
    cnt_d     = tick_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = tick_wrap ? idx_q + 2'd1 : idx_q;
    pend_d    = load ? 1'b0 : (pend_q | upd);
    code_d    = load ? {seg3wr, seg2wr, seg1wr, seg0wr} : code_q;
    sdp_d     = load ? dp_in : sdp_q;
    upd_ack_d = load;
  end

  // Display outputs for the current digit, registered one cycle later.
  always_comb begin
    an_d = ~(4'b0001 << idx_q);
    if (blank_an) an_d = 4'b1111;
    seg_d = decode(code_q[idx_q]);
    dp_d  = ~sdp_q[idx_q];
    // State (idx 0, cnt 0) occurs exactly once per frame: the cycle before
    // digit 0 is shown, including the first cycle out of reset.
    fs_d  = (idx_q == 2'd0) && (cnt_q == '0);
  end

`ifdef DISP_SCAN_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] fc_q, fc_d;
  logic            phase_q, phase_d;

  // Frame counter and blink phase; both move only on frame boundaries.
  always_comb begin
    fc_d    = fc_q;
    phase_d = phase_q;
    if (frame_bnd) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
      if (!blink)               phase_d = 1'b0;
      else if (fc_q == FC_LAST) phase_d = ~phase_q;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fc_q    <= '0;
      phase_q <= 1'b0;
    end else begin
      fc_q    <= fc_d;
      phase_q <= phase_d;
    end
  end

  assign blank_an = blink && phase_q;
`else
  // blink and BLINK_FRAMES only matter when blinking is compiled in.
  logic unused_blink;
  assign unused_blink = blink | (BLINK_FRAMES == 0);
  assign blank_an     = 1'b0;
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      // NOTE: the shadow "memory" is only four small registers, so it is reset
      // to blank; otherwise garbage segments would light before the first load.
      code_q    <= {4{CODE_BLANK}};
      sdp_q     <= '0;
      upd_ack_q <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      code_q    <= code_d;
      sdp_q     <= sdp_d;
      upd_ack_q <= upd_ack_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fs_q      <= fs_d;
    end
  end

  assign upd_ack     = upd_ack_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule
